// File: rtl/trig_sequencer_pkg.sv
// Shared constants, state encoding and quadrant helpers for the trig sequencer.
package trig_sequencer_pkg;

  // Angle width shared with the divider; 10 bits covers 0..1023 degrees.
  localparam int unsigned DataWidthDefault = 10;
  localparam int unsigned MaxAngleDeg      = 720;
  localparam int unsigned DoubleSignBit    = 63;

  localparam logic FuncSin = 1'b0;
  localparam logic FuncCos = 1'b1;

  typedef enum logic [2:0] {
    TsIdle,
    TsReduce,
    TsLaunch,
    TsWaitCore,
    TsRespond
  } ts_state_e;

  // Odd quadrants swap sin and cos.
  function automatic logic quad_eff_func(input logic func, input logic [1:0] quadrant);
    return func ^ quadrant[0];
  endfunction

  // sin is negative in q2/q3, cos is negative in q1/q2.
  function automatic logic quad_negate(input logic func, input logic [1:0] quadrant);
    if (func == FuncSin) begin
      return quadrant[1];
    end
    return quadrant[1] ^ quadrant[0];
  endfunction

endpackage

// File: rtl/trig_quadrant_fixup.sv
// Quadrant identity: maps requested function and quadrant to the function the
// core must evaluate and whether the core result needs its sign flipped.
module trig_quadrant_fixup
  import trig_sequencer_pkg::*;
(
  input  logic       func,
  input  logic [1:0] quadrant,
  output logic       eff_func,
  output logic       negate
);

  // Pure table lookup, no state.
  always_comb begin
    eff_func = quad_eff_func(func, quadrant);
    negate   = quad_negate(func, quadrant);
  end

endmodule

// File: rtl/trig_sequencer.sv
// Control FSM for one trig evaluation: range-reduce via the divider, launch the
// FP trig core on the in-quadrant offset, sign-correct the double result and
// return it over a valid/ready response port. One transaction in flight.
module trig_sequencer
  import trig_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DataWidthDefault,
  parameter int unsigned RESULT_WIDTH = 64,
  parameter int unsigned MAX_ANGLE    = MaxAngleDeg,
  parameter int unsigned DIV_LATENCY  = 1,
  parameter int unsigned CORE_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  // Request port
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH-1:0]   req_angle,
  input  logic                    req_func,
  // Divider
  output logic                    div_en,
  output logic [DATA_WIDTH-1:0]   div_data_in,
  input  logic [1:0]              div_quadrant,
  input  logic [DATA_WIDTH-1:0]   div_data_out,
  // Trig core
  output logic                    core_start,
  output logic [DATA_WIDTH-1:0]   core_angle,
  output logic                    core_func,
  input  logic                    core_done,
  input  logic [RESULT_WIDTH-1:0] core_result,
  // Response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RESULT_WIDTH-1:0] rsp_result,
  output logic                    rsp_error
);

  localparam int unsigned DivCntW = (DIV_LATENCY > 0) ? $clog2(DIV_LATENCY + 1) : 1;
  localparam int unsigned ToCntW  = (CORE_TIMEOUT > 1) ? $clog2(CORE_TIMEOUT + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] MaxAngleW = DATA_WIDTH'(MAX_ANGLE);
  localparam logic [DivCntW-1:0]    DivCntLoad = DivCntW'(DIV_LATENCY);
  localparam logic [ToCntW-1:0]     ToCntLast  = ToCntW'(CORE_TIMEOUT - 1);
  localparam int unsigned           SignBit    = RESULT_WIDTH - 1;

  ts_state_e               state_q;
  logic [DivCntW-1:0]      div_cnt_q;
  logic [ToCntW-1:0]       to_cnt_q;
  logic                    func_q;
  logic                    negate_q;
  logic                    got_q;
  logic [RESULT_WIDTH-1:0] result_q;

  logic                    req_ready_q;
  logic                    div_en_q;
  logic [DATA_WIDTH-1:0]   div_data_in_q;
  logic                    core_start_q;
  logic [DATA_WIDTH-1:0]   core_angle_q;
  logic                    core_func_q;
  logic                    rsp_valid_q;
  logic [RESULT_WIDTH-1:0] rsp_result_q;
  logic                    rsp_error_q;

  logic eff_func;
  logic negate;

  // Fed straight from the divider so the fixup is ready on the edge that ends REDUCE.
  trig_quadrant_fixup u_fixup (
    .func     (func_q),
    .quadrant (div_quadrant),
    .eff_func (eff_func),
    .negate   (negate)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= TsIdle;
      div_cnt_q     <= '0;
      to_cnt_q      <= '0;
      func_q        <= 1'b0;
      negate_q      <= 1'b0;
      got_q         <= 1'b0;
      result_q      <= '0;
      req_ready_q   <= 1'b0;
      div_en_q      <= 1'b0;
      div_data_in_q <= '0;
      core_start_q  <= 1'b0;
      core_angle_q  <= '0;
      core_func_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_error_q   <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        TsIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            func_q      <= req_func;
            if (req_angle > MaxAngleW) begin
              // Out-of-range angles never touch the divider or core.
              state_q      <= TsRespond;
              rsp_valid_q  <= 1'b1;
              rsp_error_q  <= 1'b1;
              rsp_result_q <= '0;
            end else begin
              state_q       <= TsReduce;
              div_en_q      <= 1'b1;
              div_data_in_q <= req_angle;
              div_cnt_q     <= DivCntLoad;
            end
          end
        end

        TsReduce: begin
          if (div_cnt_q == '0) begin
            div_en_q      <= 1'b0;
            div_data_in_q <= '0;
            core_start_q  <= 1'b1;
            core_angle_q  <= div_data_out;
            core_func_q   <= eff_func;
            negate_q      <= negate;
            state_q       <= TsLaunch;
          end else begin
            div_cnt_q <= div_cnt_q - 1'b1;
          end
        end

        TsLaunch: begin
          to_cnt_q <= '0;
          got_q    <= 1'b0;
          state_q  <= TsWaitCore;
        end

        TsWaitCore: begin
          // core_done is captured first, so it beats a timeout in the same cycle.
          if (got_q) begin
            state_q      <= TsRespond;
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= 1'b0;
            rsp_result_q <= result_q;
          end else if (core_done) begin
            got_q    <= 1'b1;
            result_q <= {core_result[SignBit] ^ negate_q, core_result[SignBit-1:0]};
          end else if (to_cnt_q == ToCntLast) begin
            state_q      <= TsRespond;
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= 1'b1;
            rsp_result_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        TsRespond: begin
          if (rsp_ready) begin
            state_q      <= TsIdle;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_result_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end

        default: state_q <= TsIdle;
      endcase
    end
  end

  // Outputs are straight register taps.
  always_comb begin
    req_ready   = req_ready_q;
    div_en      = div_en_q;
    div_data_in = div_data_in_q;
    core_start  = core_start_q;
    core_angle  = core_angle_q;
    core_func   = core_func_q;
    rsp_valid   = rsp_valid_q;
    rsp_result  = rsp_result_q;
    rsp_error   = rsp_error_q;
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer with a registered divider model and a
// scripted trig core.
module tb_trig_sequencer;

  localparam int CoreTimeout = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_angle = '0;
  logic        req_func = 1'b0;
  logic        div_en;
  logic [9:0]  div_data_in;
  logic [1:0]  div_quadrant = '0;
  logic [9:0]  div_data_out = '0;
  logic        core_start;
  logic [9:0]  core_angle;
  logic        core_func;
  logic        core_done = 1'b0;
  logic [63:0] core_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trig_sequencer #(
    .DATA_WIDTH   (10),
    .RESULT_WIDTH (64),
    .MAX_ANGLE    (720),
    .DIV_LATENCY  (1),
    .CORE_TIMEOUT (CoreTimeout)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_angle    (req_angle),
    .req_func     (req_func),
    .div_en       (div_en),
    .div_data_in  (div_data_in),
    .div_quadrant (div_quadrant),
    .div_data_out (div_data_out),
    .core_start   (core_start),
    .core_angle   (core_angle),
    .core_func    (core_func),
    .core_done    (core_done),
    .core_result  (core_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_error    (rsp_error)
  );

  // One-stage divider: angle mod 360 split into quadrant and offset.
  always_ff @(posedge clk) begin
    if (div_en) begin
      div_quadrant <= 2'((int'(div_data_in) % 360) / 90);
      div_data_out <= 10'((int'(div_data_in) % 360) % 90);
    end
  end

  // Runs one transaction; core_lat < 0 means the core never answers.
  // Cycle 0 is the request handshake cycle; latencies are in that numbering.
  task automatic do_txn(input logic [9:0] angle, input logic func, input int core_lat,
                        input logic [63:0] core_res, input int hold,
                        output logic [9:0] o_core_angle, output logic o_core_func,
                        output logic [63:0] o_result, output logic o_error,
                        output int o_latency, output int o_launch_to_rsp,
                        output int o_div_cycles, output bit o_div_data_ok,
                        output bit o_hold_ok, output bit o_done);
    int  cyc;
    int  tl;
    bit  launched;
    o_core_angle = 'x; o_core_func = 1'bx; o_result = 'x; o_error = 1'bx;
    o_latency = -1; o_launch_to_rsp = -1; o_div_cycles = 0;
    o_div_data_ok = 1'b1; o_hold_ok = 1'b1; o_done = 1'b0;
    launched = 1'b0; tl = 0;
    req_angle = angle; req_func = func; req_valid = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < 10 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 600) begin
      if (div_en) begin
        o_div_cycles++;
        if (div_data_in !== angle) o_div_data_ok = 1'b0;
      end
      if (core_start) begin
        launched = 1'b1; tl = cyc;
        o_core_angle = core_angle; o_core_func = core_func;
      end
      core_done   = launched && core_lat >= 0 && cyc == tl + core_lat;
      core_result = core_done ? core_res : 64'hDEAD_BEEF_DEAD_BEEF;
      if (rsp_valid) begin
        o_result = rsp_result; o_error = rsp_error; o_latency = cyc;
        if (launched) o_launch_to_rsp = cyc - tl;
        core_done = 1'b0;
        for (int k = 0; k < hold; k++) begin
          @(posedge clk); #1;
          if (rsp_valid !== 1'b1 || rsp_result !== o_result || rsp_error !== o_error ||
              req_ready !== 1'b0) o_hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0) o_hold_ok = 1'b0;
        o_done = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, div_en, div_data_in, core_start, core_angle, core_func, rsp_valid,
         rsp_result, rsp_error} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req_ready=%b div_en=%b core_start=%b rsp_valid=%b rsp_result=%h rsp_error=%b, need all 0",
               req_ready, div_en, core_start, rsp_valid, rsp_result, rsp_error);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_req_ready: got %b need 1", req_ready);
    end
  endtask

  task automatic test_sin_q0();
    logic [9:0] ca; logic cf; logic [63:0] res; logic err;
    int lat, l2r, dc; bit dok, hok, done;
    do_txn(10'd30, 1'b0, 3, 64'h3FE0000000000000, 0, ca, cf, res, err, lat, l2r, dc, dok, hok,
           done);
    n_cmp++;
    if (!done || ca !== 10'd30 || cf !== 1'b0) begin
      n_bad++;
      $display("FAIL sin30_core: got done=%0d angle=%0d func=%b need 1/30/0", done, ca, cf);
    end
    n_cmp++;
    if (res !== 64'h3FE0000000000000 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL sin30_rsp: got %h err=%b need 3fe0000000000000 err=0", res, err);
    end
    n_cmp++;
    if (lat !== 8) begin
      n_bad++;
      $display("FAIL sin30_latency: got %0d need 8", lat);
    end
    n_cmp++;
    if (dc !== 2 || !dok) begin
      n_bad++;
      $display("FAIL sin30_div: got cycles=%0d data_ok=%0d need 2/1", dc, dok);
    end
  endtask

  task automatic test_quadrants();
    logic [9:0]  ang [6] = '{10'd210, 10'd120, 10'd300, 10'd100, 10'd720, 10'd450};
    logic        fn  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [63:0] cr  [6] = '{64'h3FE0000000000000, 64'h3FE0000000000000,
                             64'h3FEBB67AE8584CAA, 64'h3FEF838B8C811C17,
                             64'h0, 64'h0};
    logic [9:0]  xa  [6] = '{10'd30, 10'd30, 10'd30, 10'd10, 10'd0, 10'd0};
    logic        xf  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] xr  [6] = '{64'hBFE0000000000000, 64'hBFE0000000000000,
                             64'hBFEBB67AE8584CAA, 64'h3FEF838B8C811C17,
                             64'h0, 64'h8000000000000000};
    logic [9:0] ca; logic cf; logic [63:0] res; logic err;
    int lat, l2r, dc; bit dok, hok, done;
    for (int i = 0; i < 6; i++) begin
      do_txn(ang[i], fn[i], 2 + i, cr[i], 0, ca, cf, res, err, lat, l2r, dc, dok, hok, done);
      n_cmp++;
      if (!done || ca !== xa[i] || cf !== xf[i]) begin
        n_bad++;
        $display("FAIL quad_core[%0d]: got done=%0d angle=%0d func=%b need 1/%0d/%b",
                 ang[i], done, ca, cf, xa[i], xf[i]);
      end
      n_cmp++;
      if (res !== xr[i] || err !== 1'b0) begin
        n_bad++;
        $display("FAIL quad_rsp[%0d]: got %h err=%b need %h err=0", ang[i], res, err, xr[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [9:0]  ang [2] = '{10'd721, 10'd1023};
    logic [9:0] ca; logic cf; logic [63:0] res; logic err;
    int lat, l2r, dc; bit dok, hok, done;
    for (int i = 0; i < 2; i++) begin
      do_txn(ang[i], 1'b0, 3, 64'h3FF0000000000000, 0, ca, cf, res, err, lat, l2r, dc, dok,
             hok, done);
      n_cmp++;
      if (!done || res !== 64'h0 || err !== 1'b1) begin
        n_bad++;
        $display("FAIL oor_rsp[%0d]: got done=%0d %h err=%b need 1/0/1", ang[i], done, res, err);
      end
      n_cmp++;
      if (dc !== 0 || l2r !== -1 || lat !== 1) begin
        n_bad++;
        $display("FAIL oor_path[%0d]: got div=%0d launch=%0d lat=%0d need 0/-1/1",
                 ang[i], dc, l2r, lat);
      end
    end
  endtask

  task automatic test_timeout();
    logic [9:0] ca; logic cf; logic [63:0] res; logic err;
    int lat, l2r, dc; bit dok, hok, done;
    do_txn(10'd45, 1'b0, -1, 64'h0, 0, ca, cf, res, err, lat, l2r, dc, dok, hok, done);
    n_cmp++;
    if (!done || err !== 1'b1 || res !== 64'h0) begin
      n_bad++;
      $display("FAIL timeout_rsp: got done=%0d err=%b %h need 1/1/0", done, err, res);
    end
    // WAIT_CORE spans CORE_TIMEOUT cycles after LAUNCH; the error response follows.
    n_cmp++;
    if (l2r !== CoreTimeout + 1) begin
      n_bad++;
      $display("FAIL timeout_cycles: got %0d need %0d", l2r, CoreTimeout + 1);
    end
    core_result = 64'h3FF0000000000000;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || core_start !== 1'b0) begin
      n_bad++;
      $display("FAIL late_done: got rsp_valid=%b req_ready=%b core_start=%b need 0/1/0",
               rsp_valid, req_ready, core_start);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] ca; logic cf; logic [63:0] res; logic err;
    int lat, l2r, dc; bit dok, hok, done;
    do_txn(10'd210, 1'b0, 3, 64'h3FE0000000000000, 5, ca, cf, res, err, lat, l2r, dc, dok,
           hok, done);
    n_cmp++;
    if (!done || !hok || res !== 64'hBFE0000000000000) begin
      n_bad++;
      $display("FAIL backpressure: got done=%0d stable=%0d %h need 1/1/bfe0000000000000",
               done, hok, res);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    req_angle = 10'd30; req_func = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 10 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      seen = core_start;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL mid_launch: got core_start=0 need 1 within 10 cycles");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({req_ready, div_en, div_data_in, core_start, core_angle, core_func, rsp_valid,
         rsp_result, rsp_error} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got req_ready=%b core_angle=%0d rsp_valid=%b need all 0",
               req_ready, core_angle, rsp_valid);
    end
    reset = 1'b0;
    core_result = 64'h3FE0000000000000;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_recover: got req_ready=%b rsp_valid=%b need 1/0", req_ready, rsp_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_rsp: got rsp_valid=%b need 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] ca; logic cf; logic [63:0] res; logic err;
    int lat, l2r, dc; bit dok, hok, done;
    do_txn(10'd721, 1'b1, 3, 64'h0, 0, ca, cf, res, err, lat, l2r, dc, dok, hok, done);
    do_txn(10'd120, 1'b1, 1, 64'h3FE0000000000000, 0, ca, cf, res, err, lat, l2r, dc, dok, hok,
           done);
    n_cmp++;
    if (!done || cf !== 1'b0 || res !== 64'hBFE0000000000000 || err !== 1'b0 || lat !== 6) begin
      n_bad++;
      $display("FAIL b2b: got done=%0d func=%b %h err=%b lat=%0d need 1/0/bfe0000000000000/0/6",
               done, cf, res, err, lat);
    end
  endtask

  initial begin
    test_reset();
    test_sin_q0();
    test_quadrants();
    test_out_of_range();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
